// File: rtl/rgb_seq_pkg.sv
// rgb_seq_pkg: shared types and constants for the RGB status sequencer.
//   color_idx_t  - 4-bit colour index understood by the LED colour selector
//   seq_state_t  - sequencer states
//   COLOR_OFF    - dark index
//   COLOR_DIM_BIT- selects the low-current variant of colours 1..7
package rgb_seq_pkg;

  typedef logic [3:0] color_idx_t;

  localparam color_idx_t COLOR_OFF     = 4'h0;
  localparam color_idx_t COLOR_DIM_BIT = 4'h8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STEADY,
    ST_ON,
    ST_OFF,
    ST_GAP
  } seq_state_t;

  // Colours 1..7 have a dim twin at index | 8; anything else goes dark.
  function automatic color_idx_t dim_color(input color_idx_t c);
    if (c >= 4'd1 && c <= 4'd7) return c | COLOR_DIM_BIT;
    return COLOR_OFF;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk down to a one-cycle tick strobe.
//   clk   - system clock
//   reset - synchronous active-high reset
//   clear - restart the count from 0 (pattern start alignment)
//   tick  - high for one cycle every TICK_CYCLES cycles (TICK_CYCLES >= 2)
module tick_prescaler #(
  parameter int TICK_CYCLES = 2_400_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(TICK_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) cnt <= '0;
    else if (cnt == CNT_LAST) cnt <= '0;
    else cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/rgb_status_sequencer.sv
// rgb_status_sequencer: turns status requests into timed colour_index
// sequences (steady colour, or N blinks + dark gap, once or looping).
//   clk, reset             - system clock, synchronous active-high reset
//   req_valid/req_ready    - request handshake
//   req_color/count/repeat - pattern description, latched on accept
//   color_index            - registered colour index to the colour selector
//   busy                   - pattern active
//   done                   - one-cycle pulse when a one-shot pattern ends
// Build option: RGB_SEQ_DIM_EN shows the dim colour variant during OFF.
//
// state     | meaning
// ST_IDLE   | no pattern, output dark
// ST_STEADY | latched colour shown until the next request
// ST_ON     | blink lit phase
// ST_OFF    | blink dark phase, blink counter decremented at its end
// ST_GAP    | dark pause after the last blink, then loop or finish
module rgb_status_sequencer
  import rgb_seq_pkg::*;
#(
  parameter int TICK_CYCLES = 2_400_000,
  parameter int ON_TICKS    = 2,
  parameter int OFF_TICKS   = 2,
  parameter int GAP_TICKS   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_color,
  input  logic [3:0] req_count,
  input  logic       req_repeat,
  output logic [3:0] color_index,
  output logic       busy,
  output logic       done
);

  localparam int MAX_A     = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int MAX_TICKS = (MAX_A > GAP_TICKS) ? MAX_A : GAP_TICKS;
  localparam int PW        = $clog2(MAX_TICKS + 1);
  localparam logic [PW-1:0] ON_LD  = PW'(ON_TICKS);
  localparam logic [PW-1:0] OFF_LD = PW'(OFF_TICKS);
  localparam logic [PW-1:0] GAP_LD = PW'(GAP_TICKS);

  seq_state_t    state, state_nxt;
  logic [PW-1:0] phase_cnt, phase_nxt;
  logic [3:0]    blink_cnt, blink_nxt;
  color_idx_t    color_q, color_nxt, color_src;
  logic [3:0]    count_q;
  logic          repeat_q;
  logic          done_nxt;
  logic          tick;
  logic          accept;

  tick_prescaler #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .tick  (tick)
  );

  // Looping patterns stay preemptible; one-shots run to completion.
  always_comb begin
    case (state)
      ST_IDLE, ST_STEADY: req_ready = 1'b1;
      default:            req_ready = repeat_q;
    endcase
  end

  assign accept = req_valid && req_ready;
  assign busy   = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    phase_nxt = phase_cnt;
    blink_nxt = blink_cnt;
    done_nxt  = 1'b0;
    color_src = accept ? req_color : color_q;
    if (accept) begin
      if (req_count == 4'd0) begin
        state_nxt = ST_STEADY;
        phase_nxt = '0;
        blink_nxt = 4'd0;
      end else begin
        state_nxt = ST_ON;
        phase_nxt = ON_LD;
        blink_nxt = req_count;
      end
    end else if (tick) begin
      // Phase counter is a down-counter; a tick at 1 is the terminal count.
      case (state)
        ST_ON: begin
          if (phase_cnt == PW'(1)) begin
            state_nxt = ST_OFF;
            phase_nxt = OFF_LD;
          end else phase_nxt = phase_cnt - 1'b1;
        end
        ST_OFF: begin
          if (phase_cnt == PW'(1)) begin
            blink_nxt = blink_cnt - 4'd1;
            if (blink_cnt == 4'd1) begin
              state_nxt = ST_GAP;
              phase_nxt = GAP_LD;
            end else begin
              state_nxt = ST_ON;
              phase_nxt = ON_LD;
            end
          end else phase_nxt = phase_cnt - 1'b1;
        end
        ST_GAP: begin
          if (phase_cnt == PW'(1)) begin
            if (repeat_q) begin
              state_nxt = ST_ON;
              phase_nxt = ON_LD;
              blink_nxt = count_q;
            end else begin
              state_nxt = ST_IDLE;
              phase_nxt = '0;
              done_nxt  = 1'b1;
            end
          end else phase_nxt = phase_cnt - 1'b1;
        end
        default: ;
      endcase
    end

    // Output is registered, so it follows the state being entered.
    case (state_nxt)
      ST_ON, ST_STEADY: color_nxt = color_src;
`ifdef RGB_SEQ_DIM_EN
      ST_OFF:           color_nxt = dim_color(color_src);
`endif
      default:          color_nxt = COLOR_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      phase_cnt   <= '0;
      blink_cnt   <= 4'd0;
      color_q     <= COLOR_OFF;
      count_q     <= 4'd0;
      repeat_q    <= 1'b0;
      color_index <= COLOR_OFF;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      phase_cnt   <= phase_nxt;
      blink_cnt   <= blink_nxt;
      color_index <= color_nxt;
      done        <= done_nxt;
      if (accept) begin
        color_q  <= req_color;
        count_q  <= req_count;
        repeat_q <= req_repeat;
      end
    end
  end

endmodule

// File: tb/tb_rgb_status_sequencer.sv
// tb_rgb_status_sequencer: directed scenarios plus random requests/resets,
// compared every cycle against a timeline model of the expected pattern.
module tb_rgb_status_sequencer;

  localparam int T   = 4;
  localparam int ON  = 2;
  localparam int OFF = 1;
  localparam int GAP = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_color;
  logic [3:0] req_count;
  logic       req_repeat;
  logic [3:0] color_index;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  rgb_status_sequencer #(
    .TICK_CYCLES (T),
    .ON_TICKS    (ON),
    .OFF_TICKS   (OFF),
    .GAP_TICKS   (GAP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_color   (req_color),
    .req_count   (req_count),
    .req_repeat  (req_repeat),
    .color_index (color_index),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Model: position p = cycles since the accept edge minus one.
  bit         m_active = 1'b0;
  int         m_p      = 0;
  logic [3:0] m_col    = 4'h0;
  int         m_cnt    = 0;
  bit         m_rep    = 1'b0;
  bit         m_done   = 1'b0;

  function automatic int m_period();
    return m_cnt * (ON + OFF) * T + GAP * T;
  endfunction

  function automatic bit m_ready();
    return !m_active || (m_cnt == 0) || m_rep;
  endfunction

  function automatic logic [3:0] m_color();
    int q;
    int r;
    if (!m_active) return 4'h0;
    if (m_cnt == 0) return m_col;
    q = m_p % m_period();
    if (q >= m_cnt * (ON + OFF) * T) return 4'h0;
    r = q % ((ON + OFF) * T);
    if (r < ON * T) return m_col;
`ifdef RGB_SEQ_DIM_EN
    if (m_col >= 4'd1 && m_col <= 4'd7) return m_col | 4'h8;
`endif
    return 4'h0;
  endfunction

  task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; ends at the next negedge with outputs checked.
  task automatic step(input bit v, input logic [3:0] c, input logic [3:0] n,
                      input bit r, input bit rst);
    bit rdy;
    req_valid  = v;
    req_color  = c;
    req_count  = n;
    req_repeat = r;
    reset      = rst;
    rdy = m_ready();
    check_val("ready", {3'b0, req_ready}, {3'b0, rdy});
    @(posedge clk);
    if (rst) begin
      m_active = 1'b0;
      m_done   = 1'b0;
    end else if (v && rdy) begin
      m_active = 1'b1;
      m_p      = 0;
      m_col    = c;
      m_cnt    = int'(n);
      m_rep    = r;
      m_done   = 1'b0;
    end else if (m_active) begin
      m_p++;
      m_done = 1'b0;
      if (m_cnt != 0 && !m_rep && m_p == m_period()) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end else m_done = 1'b0;
    @(negedge clk);
    check_val("color", color_index, m_color());
    check_val("busy", {3'b0, busy}, {3'b0, m_active});
    check_val("done", {3'b0, done}, {3'b0, m_done});
  endtask

  task automatic idle_steps(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    req_valid  = 1'b0;
    req_color  = 4'h0;
    req_count  = 4'h0;
    req_repeat = 1'b0;
    reset      = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_color", color_index, 4'h0);
    check_val("rst_busy", {3'b0, busy}, 4'h0);
    check_val("rst_done", {3'b0, done}, 4'h0);
    check_val("rst_ready", {3'b0, req_ready}, 4'h1);
    reset = 1'b0;

    // One-shot blink, anchored to absolute cycle numbers as well.
    step(1'b1, 4'h1, 4'd2, 1'b0, 1'b0);
    for (int i = 1; i <= 40; i++) begin
      step(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      if (i == 1)  check_val("s1_c2", color_index, 4'h1);
`ifdef RGB_SEQ_DIM_EN
      if (i == 9)  check_val("s1_c10_dim", color_index, 4'h9);
`else
      if (i == 9)  check_val("s1_c10", color_index, 4'h0);
`endif
      if (i == 25) check_val("s1_gap", color_index, 4'h0);
      if (i == 36) check_val("s1_done37", {3'b0, done}, 4'h1);
    end

    // Steady, then switch colour.
    step(1'b1, 4'h4, 4'd0, 1'b0, 1'b0);
    idle_steps(200);
    step(1'b1, 4'h2, 4'd0, 1'b0, 1'b0);
    check_val("s2_switch", color_index, 4'h2);
    idle_steps(5);

    // Looping pattern preempted mid-ON.
    step(1'b1, 4'h6, 4'd1, 1'b1, 1'b0);
    idle_steps(49);
    step(1'b1, 4'h3, 4'd0, 1'b0, 1'b0);
    check_val("s3_preempt", color_index, 4'h3);
    idle_steps(5);

    // One-shot with a request held valid throughout.
    step(1'b1, 4'h2, 4'd1, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b1, 4'h7, 4'd0, 1'b0, 1'b0);
    check_val("s4_after", color_index, 4'h7);
    idle_steps(3);

    // Reset mid-OFF, then color 0 and count 15 boundaries.
    step(1'b1, 4'h5, 4'd3, 1'b0, 1'b0);
    idle_steps(9);
    step(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
    check_val("s5_color", color_index, 4'h0);
    check_val("s5_busy", {3'b0, busy}, 4'h0);
    check_val("s5_ready", {3'b0, req_ready}, 4'h1);
    step(1'b1, 4'h0, 4'd15, 1'b0, 1'b0);
    idle_steps(200);
    step(1'b1, 4'hC, 4'd15, 1'b0, 1'b0);
    idle_steps(200);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 24) == 0,
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 5)),
           1'($urandom_range(0, 1)),
           $urandom_range(0, 399) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
